// File: rtl/fetch_q_pkg.sv
// Shared types for the fetch queue: queue entry layout, syscall encoding and
// issue-sequencer states.
package fetch_q_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    localparam logic [31:0] SYSCALL_INSTR = 32'h0000000c;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        ISSUE  = 2'd2,
        BUBBLE = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_q_fifo.sv
// Circular {instr, pc} store with read/write pointers and occupancy count.
// Flush clears pointers and count and overrides push/pop in the same cycle.
module fetch_q_fifo
    import fetch_q_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [31:0]                wr_instr,
    input  logic [31:0]                wr_pc,
    output logic [31:0]                head_instr,
    output logic [31:0]                head_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;

    // Pointers are exactly AW bits wide, so the power-of-two depth wraps for free.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{instr: wr_instr, pc: wr_pc};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_instr = mem[rd_ptr].instr;
    assign head_pc    = mem[rd_ptr].pc;
    assign count      = cnt;
    assign full       = (cnt == CW'(DEPTH));

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch-to-ID instruction queue with syscall serialisation (drain, issue alone, bubbles).
// Optional FETCHQ_BYPASS_EN offers a fetched instruction to ID in the same cycle when the queue is empty.
module fetch_queue_ctrl
    import fetch_q_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYS_BUBBLES = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                Instr_IN,
    input  logic [31:0]                Instr_PC_IN,
    input  logic                       Instr_Valid_IN,
    output logic                       Queue_Full_OUT,
    input  logic                       Request_Instr1,
    output logic [31:0]                Instr1_OUT,
    output logic [31:0]                Instr1_PC_OUT,
    output logic [31:0]                Instr_PC_Plus4_OUT,
    output logic                       Instr1_Valid_OUT,
    input  logic                       Flush_IN,
    input  logic                       STALL_fMEM,
    input  logic                       Pipe_Empty_IN,
    output logic                       SYS_Busy_OUT,
    output logic [$clog2(DEPTH):0]     Count_OUT
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state_q, state_d;
    logic [2:0]      bub_q, bub_d;
    logic [31:0]     q_instr, q_pc;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_nonempty;
    logic            head_is_sys;
    logic            bypass;
    logic            valid;
    logic            pop;
    logic            push_ok;
    logic            fifo_push;
    logic            fifo_pop;

    fetch_q_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (Flush_IN),
        .wr_instr   (Instr_IN),
        .wr_pc      (Instr_PC_IN),
        .head_instr (q_instr),
        .head_pc    (q_pc),
        .count      (q_count),
        .full       (q_full)
    );

    assign q_nonempty  = (q_count != '0);
    assign head_is_sys = q_nonempty && (q_instr == SYSCALL_INSTR);

`ifdef FETCHQ_BYPASS_EN
    // Syscalls never bypass: they must land in the queue to take the drain path.
    assign bypass        = (state_q == RUN) && !q_nonempty && Instr_Valid_IN
                           && (Instr_IN != SYSCALL_INSTR);
    assign Instr1_OUT    = bypass ? Instr_IN    : q_instr;
    assign Instr1_PC_OUT = bypass ? Instr_PC_IN : q_pc;
`else
    assign bypass        = 1'b0;
    assign Instr1_OUT    = q_instr;
    assign Instr1_PC_OUT = q_pc;
`endif

    always_comb begin
        valid = 1'b0;
        case (state_q)
            RUN:     valid = (q_nonempty && !head_is_sys) || bypass;
            ISSUE:   valid = 1'b1;
            default: valid = 1'b0;
        endcase
    end

    assign pop     = valid && Request_Instr1 && !STALL_fMEM && !Flush_IN;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = Instr_Valid_IN && (!q_full || pop) && !Flush_IN;

    assign fifo_pop  = pop && !bypass;
    assign fifo_push = push_ok && !(bypass && pop);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RUN;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        case (state_q)
            RUN: begin
                if (head_is_sys && !STALL_fMEM && !Flush_IN) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (Flush_IN) begin
                    state_d = RUN;
                end else if (Pipe_Empty_IN && !STALL_fMEM) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (Flush_IN) begin
                    state_d = RUN;
                end else if (pop) begin
                    bub_d   = 3'(SYS_BUBBLES);
                    state_d = BUBBLE;
                end
            end
            BUBBLE: begin
                // The syscall has already left, so neither stall nor flush pauses the count.
                if (bub_q <= 3'd1) begin
                    bub_d   = '0;
                    state_d = RUN;
                end else begin
                    bub_d = bub_q - 3'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign Instr1_Valid_OUT   = valid;
    assign Instr_PC_Plus4_OUT = Instr1_PC_OUT + 32'd4;
    assign Queue_Full_OUT     = q_full;
    assign Count_OUT          = q_count;
    assign SYS_Busy_OUT       = (state_q != RUN);

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl: vector table plus hand sequences for syscall, flush, stall, reset.
// Build with FETCHQ_BYPASS_EN defined to exercise the same-cycle bypass instead.
module tb_fetch_queue_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr_IN, Instr_PC_IN;
    logic        Instr_Valid_IN;
    logic        Queue_Full_OUT;
    logic        Request_Instr1;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, Instr_PC_Plus4_OUT;
    logic        Instr1_Valid_OUT;
    logic        Flush_IN, STALL_fMEM, Pipe_Empty_IN;
    logic        SYS_Busy_OUT;
    logic [3:0]  Count_OUT;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] SYS = 32'h0000000c;

    fetch_queue_ctrl #(.DEPTH(8), .SYS_BUBBLES(3)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Instr_IN           (Instr_IN),
        .Instr_PC_IN        (Instr_PC_IN),
        .Instr_Valid_IN     (Instr_Valid_IN),
        .Queue_Full_OUT     (Queue_Full_OUT),
        .Request_Instr1     (Request_Instr1),
        .Instr1_OUT         (Instr1_OUT),
        .Instr1_PC_OUT      (Instr1_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
        .Instr1_Valid_OUT   (Instr1_Valid_OUT),
        .Flush_IN           (Flush_IN),
        .STALL_fMEM         (STALL_fMEM),
        .Pipe_Empty_IN      (Pipe_Empty_IN),
        .SYS_Busy_OUT       (SYS_Busy_OUT),
        .Count_OUT          (Count_OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        vld;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        req, fl, st, pe;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        int          e_cnt;
        logic        e_full, e_busy;
    } vec_t;

    function automatic vec_t mkv(input logic vld, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic req, input logic fl, input logic st, input logic pe,
                                 input logic e_vld, input logic [31:0] e_ins, input logic [31:0] e_pc,
                                 input int e_cnt, input logic e_full, input logic e_busy);
        vec_t v;
        v.vld = vld; v.ins = ins; v.pc = pc;
        v.req = req; v.fl = fl; v.st = st; v.pe = pe;
        v.e_vld = e_vld; v.e_ins = e_ins; v.e_pc = e_pc;
        v.e_cnt = e_cnt; v.e_full = e_full; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive at the falling edge, sample 1ns later, commit at the next rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        Instr_Valid_IN = v.vld;
        Instr_IN       = v.ins;
        Instr_PC_IN    = v.pc;
        Request_Instr1 = v.req;
        Flush_IN       = v.fl;
        STALL_fMEM     = v.st;
        Pipe_Empty_IN  = v.pe;
        #1;
        chk({tag, "_valid"}, 32'(Instr1_Valid_OUT), 32'(v.e_vld));
        chk({tag, "_count"}, 32'(Count_OUT), 32'(v.e_cnt));
        chk({tag, "_full"},  32'(Queue_Full_OUT), 32'(v.e_full));
        chk({tag, "_busy"},  32'(SYS_Busy_OUT), 32'(v.e_busy));
        if (v.e_vld) begin
            chk({tag, "_instr"}, Instr1_OUT, v.e_ins);
            chk({tag, "_pc"},    Instr1_PC_OUT, v.e_pc);
            chk({tag, "_pc4"},   Instr_PC_Plus4_OUT, v.e_pc + 32'd4);
        end
        @(negedge CLK);
    endtask

    function automatic vec_t idle(input logic req, input logic pe, input logic e_vld,
                                  input logic [31:0] e_ins, input logic [31:0] e_pc,
                                  input int e_cnt, input logic e_busy);
        return mkv(1'b0, 32'h0, 32'h0, req, 1'b0, 1'b0, pe, e_vld, e_ins, e_pc, e_cnt, 1'b0, e_busy);
    endfunction

    vec_t tbl[$];

    initial begin
        RESET = 1'b1;
        Instr_Valid_IN = 1'b0; Instr_IN = '0; Instr_PC_IN = '0;
        Request_Instr1 = 1'b0; Flush_IN = 1'b0; STALL_fMEM = 1'b0; Pipe_Empty_IN = 1'b1;
        @(negedge CLK);
        chk("rst_valid", 32'(Instr1_Valid_OUT), 32'h0);
        chk("rst_full",  32'(Queue_Full_OUT), 32'h0);
        chk("rst_busy",  32'(SYS_Busy_OUT), 32'h0);
        chk("rst_count", 32'(Count_OUT), 32'h0);
        chk("rst_instr", Instr1_OUT, 32'h0);
        chk("rst_pc",    Instr1_PC_OUT, 32'h0);
        RESET = 1'b0;

`ifdef FETCHQ_BYPASS_EN
        run_vec(mkv(1, 32'h00851020, 32'h9000, 1, 0, 0, 1, 1, 32'h00851020, 32'h9000, 0, 0, 0), "byp_push");
        run_vec(idle(1, 1, 0, 0, 0, 0, 0), "byp_after");
        run_vec(mkv(1, SYS, 32'h9004, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "byp_sys_push");
        run_vec(idle(1, 1, 0, 0, 0, 1, 0), "byp_sys_run");
        run_vec(idle(1, 1, 0, 0, 0, 1, 1), "byp_sys_drain");
        run_vec(idle(1, 1, 1, SYS, 32'h9004, 1, 1), "byp_sys_issue");
`else
        // In-order flow, one pop per cycle once the first entry lands.
        tbl.push_back(idle(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 32'h11111111, 32'h400000, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, 32'h22222222, 32'h400004, 1, 0, 0, 1, 1, 32'h11111111, 32'h400000, 1, 0, 0));
        tbl.push_back(mkv(1, 32'h33333333, 32'h400008, 1, 0, 0, 1, 1, 32'h22222222, 32'h400004, 1, 0, 0));
        tbl.push_back(idle(1, 1, 1, 32'h33333333, 32'h400008, 1, 0));
        tbl.push_back(idle(1, 1, 0, 0, 0, 0, 0));
        // Fill to full, drop a 9th push, then push+pop while full and drain across the wrap.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mkv(1, 32'hA0000000 + 32'(i), 32'h1000 + 32'(4 * i), 0, 0, 0, 1,
                              i > 0, 32'hA0000000, 32'h1000, i, 0, 0));
        tbl.push_back(mkv(1, 32'hA0000008, 32'h1020, 0, 0, 0, 1, 1, 32'hA0000000, 32'h1000, 8, 1, 0));
        tbl.push_back(mkv(1, 32'hB0000000, 32'h2000, 1, 0, 0, 1, 1, 32'hA0000000, 32'h1000, 8, 1, 0));
        for (int j = 1; j < 8; j++)
            tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 1, 32'hA0000000 + 32'(j), 32'h1000 + 32'(4 * j),
                              (j == 1) ? 8 : 9 - j, j == 1, 0));
        tbl.push_back(idle(1, 1, 1, 32'hB0000000, 32'h2000, 1, 0));
        tbl.push_back(idle(1, 1, 0, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++)
            run_vec(tbl[k], $sformatf("tbl%0d", k));

        // Syscall held in DRAIN until the back end empties, then issued alone, then 3 bubbles.
        run_vec(mkv(1, SYS, 32'h3000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sys_push");
        run_vec(mkv(1, 32'h22220000, 32'h3004, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sys_run");
        for (int c = 0; c < 4; c++)
            run_vec(idle(1, 0, 0, 0, 0, 2, 1), $sformatf("sys_drain%0d", c));
        run_vec(idle(1, 1, 0, 0, 0, 2, 1), "sys_drain_go");
        run_vec(idle(1, 1, 1, SYS, 32'h3000, 2, 1), "sys_issue");
        for (int b = 0; b < 3; b++)
            run_vec(idle(1, 1, 0, 0, 0, 1, 1), $sformatf("sys_bub%0d", b));
        run_vec(idle(1, 1, 1, 32'h22220000, 32'h3004, 1, 0), "sys_next");
        run_vec(idle(1, 1, 0, 0, 0, 0, 0), "sys_empty");

        // Memory stall holds the head, then it resumes in order.
        run_vec(mkv(1, 32'h44440001, 32'h4000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "stl_push1");
        run_vec(mkv(1, 32'h44440002, 32'h4004, 0, 0, 0, 1, 1, 32'h44440001, 32'h4000, 1, 0, 0), "stl_push2");
        for (int s = 0; s < 2; s++)
            run_vec(mkv(0, 0, 0, 1, 0, 1, 1, 1, 32'h44440001, 32'h4000, 2, 0, 0), $sformatf("stl_hold%0d", s));
        run_vec(idle(1, 1, 1, 32'h44440001, 32'h4000, 2, 0), "stl_pop1");
        run_vec(idle(1, 1, 1, 32'h44440002, 32'h4004, 1, 0), "stl_pop2");

        // Stall during BUBBLE does not stretch the bubble.
        run_vec(mkv(1, SYS, 32'h5000, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "sb_push");
        run_vec(mkv(1, 32'h33330000, 32'h5004, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0), "sb_run");
        run_vec(idle(1, 1, 0, 0, 0, 2, 1), "sb_drain");
        run_vec(idle(1, 1, 1, SYS, 32'h5000, 2, 1), "sb_issue");
        for (int b = 0; b < 3; b++)
            run_vec(mkv(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1), $sformatf("sb_bub%0d", b));
        run_vec(idle(1, 1, 1, 32'h33330000, 32'h5004, 1, 0), "sb_next");
        run_vec(idle(1, 1, 0, 0, 0, 0, 0), "sb_empty");

        // Flush with 5 queued, coinciding with a push and a pop request.
        for (int f = 0; f < 5; f++)
            run_vec(mkv(1, 32'hC0000000 + 32'(f), 32'h6000 + 32'(4 * f), 0, 0, 0, 1,
                        f > 0, 32'hC0000000, 32'h6000, f, 0, 0), $sformatf("fl_fill%0d", f));
        run_vec(mkv(1, 32'hDDDDDDDD, 32'h7000, 1, 1, 0, 1, 1, 32'hC0000000, 32'h6000, 5, 0, 0), "fl_cycle");
        run_vec(idle(1, 1, 0, 0, 0, 0, 0), "fl_after");
        run_vec(mkv(1, 32'h55550000, 32'h7004, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "fl_push");
        run_vec(idle(1, 1, 1, 32'h55550000, 32'h7004, 1, 0), "fl_head");
        run_vec(idle(1, 1, 0, 0, 0, 0, 0), "fl_empty");

        // Flush while draining kills the syscall and returns to RUN.
        run_vec(mkv(1, SYS, 32'h8000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fd_push");
        run_vec(idle(1, 0, 0, 0, 0, 1, 0), "fd_run");
        run_vec(idle(1, 0, 0, 0, 0, 1, 1), "fd_drain");
        run_vec(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1), "fd_flush");
        run_vec(idle(1, 0, 0, 0, 0, 0, 0), "fd_after");

        // Asynchronous reset mid-operation.
        run_vec(mkv(1, 32'h66660001, 32'hA000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "ar_push1");
        run_vec(mkv(1, 32'h66660002, 32'hA004, 0, 0, 0, 1, 1, 32'h66660001, 32'hA000, 1, 0, 0), "ar_push2");
        Instr_Valid_IN = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        chk("ar_count", 32'(Count_OUT), 32'h0);
        chk("ar_valid", 32'(Instr1_Valid_OUT), 32'h0);
        chk("ar_instr", Instr1_OUT, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        run_vec(idle(1, 1, 0, 0, 0, 0, 0), "ar_after");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
